srlatch_driver: RTL and testbench

- Clocked controller that drives a cross-coupled NAND SR latch with active-low set (s_n) and reset (r_n) inputs.
- Turns single-cycle set/clear requests into timed, never-overlapping active-low pulses with a guard interval.
- Reads the latch output back through a 2-flop synchroniser and flags any mismatch.
- Sits between synchronous control logic and the asynchronous latch storage cell.

---
 rtl/srlatch_driver.sv | 123 ++++++++++++
 tb/tb_srlatch_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srlatch_driver.sv
// rtl/srlatch_driver.sv - timed, non-overlapping s_n/r_n pulse driver for a NAND SR latch with readback
module srlatch_driver #(
    parameter int PULSE_CYC  = 4,
    parameter int GUARD_CYC  = 2,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s_n,
    output logic r_n,
    output logic ready,
    output logic done,
    output logic err,
    output logic q_sync
);

    localparam int MAX_CYC = (PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             target;
    logic             target_nxt;
    logic             q_meta;

    logic             req_window;
    logic             accept_set;
    logic             accept_clr;
    logic             conflict;

    // Requests only count while ready is high; ready lags IDLE by one cycle after CHECK.
    assign req_window = (state == ST_IDLE) && ready;
    assign accept_set = req_window && set_req && !clr_req;
    assign accept_clr = req_window && clr_req && !set_req;
    assign conflict   = req_window && set_req && clr_req;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        case (state)
            ST_INIT: begin
                if (INIT_CLEAR) begin
                    target_nxt = 1'b0;
                    cnt_nxt    = PULSE_LOAD;
                    state_nxt  = ST_PULSE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept_set || accept_clr) begin
                    target_nxt = accept_set;
                    cnt_nxt    = PULSE_LOAD;
                    state_nxt  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    cnt_nxt   = GUARD_LOAD;
                    state_nxt = ST_GUARD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt == '0) begin
                    state_nxt = ST_CHECK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Drive lines follow the state one cycle late, so the low pulse starts the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_INIT;
            cnt    <= '0;
            target <= 1'b0;
            s_n    <= 1'b1;
            r_n    <= 1'b1;
            ready  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            q_meta <= 1'b0;
            q_sync <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            target <= target_nxt;
            s_n    <= !((state == ST_PULSE) && target);
            r_n    <= !((state == ST_PULSE) && !target);
            ready  <= (state == ST_IDLE) && !accept_set && !accept_clr;
            done   <= (state == ST_CHECK) && (q_sync == target);
            err    <= conflict || ((state == ST_CHECK) && (q_sync != target));
            q_meta <= q_fb;
            q_sync <= q_meta;
        end
    end

endmodule

// File: tb/tb_srlatch_driver.sv
// tb/tb_srlatch_driver.sv - randomized bench for srlatch_driver against an event-timed reference model
module tb_srlatch_driver;

    localparam int P = 4;
    localparam int G = 2;
    localparam longint NEVER = 64'h7fff_ffff_ffff;

    logic clk;
    logic rst_n;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s_n;
    logic r_n;
    logic ready;
    logic done;
    logic err;
    logic q_sync;

    int vectors;
    int miscompares;

    logic q_latch;
    logic preset_req;
    logic preset_val;
    logic stuck;
    logic stuck_val;
    logic inv_en;

    srlatch_driver #(
        .PULSE_CYC (P),
        .GUARD_CYC (G),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_req(set_req),
        .clr_req(clr_req),
        .q_fb   (q_fb),
        .s_n    (s_n),
        .r_n    (r_n),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .q_sync (q_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural NAND latch with an optional stuck-at override on its output.
    always @(s_n or r_n or preset_req) begin
        if (preset_req) q_latch = preset_val;
        else if (!s_n && r_n) q_latch = 1'b1;
        else if (s_n && !r_n) q_latch = 1'b0;
    end
    assign q_fb = stuck ? stuck_val : q_latch;

    always @(s_n or r_n) begin
        if (inv_en) begin
            assert (s_n || r_n) else $error("FAIL inv_async s_n=%b r_n=%b", s_n, r_n);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each sequence is a start edge plus a target; outputs follow from edge offsets.
    longint k;
    longint start;
    longint ready_at;
    logic   active;
    logic   tgt;
    logic   init_pend;
    logic   qs1, qs2;
    logic   qfb_pre;
    logic   e_s, e_r, e_rdy, e_done, e_err, e_qs;

    task automatic model_edge();
        longint d;
        logic   conflict;
        logic   chk;
        logic   pulse;
        logic   rdy_prev;
        if (!rst_n) begin
            e_s = 1'b1; e_r = 1'b1; e_rdy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            qs1 = 1'b0; qs2 = 1'b0; e_qs = 1'b0;
            active = 1'b0; ready_at = NEVER; init_pend = 1'b1;
        end else begin
            rdy_prev = e_rdy;
            conflict = 1'b0;
            if (init_pend) begin
                init_pend = 1'b0;
                start = k; tgt = 1'b0; active = 1'b1; ready_at = k + P + G + 2;
            end else if (rdy_prev && set_req && clr_req) begin
                conflict = 1'b1;
            end else if (rdy_prev && (set_req ^ clr_req)) begin
                start = k; tgt = set_req; active = 1'b1; ready_at = k + P + G + 2;
            end
            d      = k - start;
            pulse  = active && (d >= 1) && (d <= P);
            e_s    = !(pulse && tgt);
            e_r    = !(pulse && !tgt);
            chk    = active && (d == P + G + 1);
            e_done = chk && (qs2 == tgt);
            e_err  = conflict || (chk && (qs2 != tgt));
            if (chk) active = 1'b0;
            e_rdy  = (k >= ready_at);
            qs2    = qs1;
            qs1    = qfb_pre;
            e_qs   = qs2;
        end
    endtask

    task automatic step(input logic set_i, input logic clr_i);
        set_req = set_i;
        clr_req = clr_i;
        @(negedge clk);
        qfb_pre = q_fb;
        @(posedge clk);
        #1;
        k++;
        model_edge();
        check("s_n", s_n, e_s);
        check("r_n", r_n, e_r);
        check("ready", ready, e_rdy);
        check("done", done, e_done);
        check("err", err, e_err);
        check("q_sync", q_sync, e_qs);
        check("inv", s_n | r_n, 1);
    endtask

    task automatic do_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_s_n", s_n, 1);
        check("rst_async_r_n", r_n, 1);
        check("rst_async_done", done, 0);
        check("rst_async_err", err, 0);
        check("rst_async_ready", ready, 0);
        repeat (hold) step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && ready !== 1'b1; i++) step(1'b0, 1'b0);
        check("wait_ready", ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; k = 0;
        start = 0; ready_at = NEVER; active = 1'b0; tgt = 1'b0; init_pend = 1'b1;
        qs1 = 1'b0; qs2 = 1'b0; qfb_pre = 1'b0;
        e_s = 1'b1; e_r = 1'b1; e_rdy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_qs = 1'b0;
        set_req = 1'b0; clr_req = 1'b0; stuck = 1'b0; stuck_val = 1'b0;
        preset_val = 1'b1; preset_req = 1'b1; inv_en = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        inv_en = 1'b1;
        preset_req = 1'b0;
        check("rst_s_n", s_n, 1);
        check("rst_r_n", r_n, 1);
        check("rst_ready", ready, 0);
        check("rst_q_sync", q_sync, 0);
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;

        // Power-up clear with the latch holding 1.
        repeat (P + G + 3) step(1'b0, 1'b0);
        check("init_q_latch", q_latch, 0);

        // Plain set from q=0.
        wait_ready();
        step(1'b1, 1'b0);
        repeat (P + G + 2) step(1'b0, 1'b0);
        check("set_q_sync", q_sync, 1);

        // Conflicting requests.
        wait_ready();
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Latch stuck at 0 during a set.
        stuck = 1'b1; stuck_val = 1'b0;
        wait_ready();
        step(1'b1, 1'b0);
        repeat (P + G + 2) step(1'b0, 1'b0);
        stuck = 1'b0;

        // Clear request landing inside an active set sequence.
        wait_ready();
        step(1'b0, 1'b1);
        wait_ready();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (P + G + 2) step(1'b0, 1'b0);

        // Reset while s_n is low.
        wait_ready();
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        check("pre_rst_s_n_low", s_n, 0);
        do_reset(2);
        repeat (P + G + 4) step(1'b0, 1'b0);

        // Random traffic, stuck faults and occasional resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if ($urandom_range(0, 39) == 0) begin
                stuck = ~stuck;
                stuck_val = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                step(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8);
            end
        end
        stuck = 1'b0;
        repeat (P + G + 4) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
